// File: rtl/join_recv_xc_if.sv
// -----------------------------------------------------------------------------
// join_recv_xc_if
// AXI-Stream style bundle carrying merged 64-bit words from the receive lanes
// toward the DMA.
//   tvalid : word valid (master -> slave)
//   tready : slave can accept (slave -> master)
//   tdata  : assembled 64-bit word
//   tuser  : index of the lane the word came from
//   tlast  : last word of a programmed-length transfer
// -----------------------------------------------------------------------------
interface join_recv_xc_if #(
  parameter int CW = 2
);
  logic          tvalid;
  logic          tready;
  logic [63:0]   tdata;
  logic [CW-1:0] tuser;
  logic          tlast;

  modport master (
    output tvalid,
    output tdata,
    output tuser,
    output tlast,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tuser,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/join_recv_xc.sv
// -----------------------------------------------------------------------------
// join_recv_xc
// Receive side of the channelised PAICORE link. Each lane accepts 32-bit
// half-words over an asynchronous four-phase request/acknowledge handshake,
// pairs them into 64-bit words (first half in [63:32]) and queues them in a
// small per-lane FIFO. A round-robin arbiter merges the lanes onto one
// AXI-Stream master with a programmable-length tlast and a done pulse.
//
// Ports
//   s_axis_aclk     : sole clock
//   s_axis_aresetn  : asynchronous active-low reset
//   request         : per-lane request, asynchronous to the clock
//   din             : per-lane data, lane i at [i*32 +: 32]
//   acknowledge     : per-lane acknowledge back to PAICORE
//   m_axis          : merged output stream (tvalid/tready/tdata/tuser/tlast)
//   i_rx_len        : words per transfer, 0 = unbounded
//   o_rx_done       : one-cycle pulse after the tlast beat
// -----------------------------------------------------------------------------
module join_recv_xc #(
  parameter  int Channel    = 4,
  parameter  int FIFO_DEPTH = 2,
  localparam int CW         = (Channel > 1) ? $clog2(Channel) : 1
) (
  input  logic                   s_axis_aclk,
  input  logic                   s_axis_aresetn,
  input  logic [Channel-1:0]     request,
  input  logic [Channel*32-1:0]  din,
  output logic [Channel-1:0]     acknowledge,
  join_recv_xc_if.master         m_axis,
  input  logic [31:0]            i_rx_len,
  output logic                   o_rx_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } lane_st_e;

  // ---------------------------------------------------------------------------
  // Lane state
  // ---------------------------------------------------------------------------
  logic [Channel-1:0] r_req_s1;
  logic [Channel-1:0] r_req_s2;
  logic [Channel-1:0] r_ack;
  logic [Channel-1:0] r_half;
  lane_st_e           r_st  [Channel];
  logic [31:0]        r_hi  [Channel];
  logic [63:0]        r_mem [Channel][FIFO_DEPTH];
  logic [AW-1:0]      r_wp  [Channel];
  logic [AW-1:0]      r_rp  [Channel];
  logic [NW-1:0]      r_cnt [Channel];

  logic [Channel-1:0] w_slot;
  logic [Channel-1:0] w_cap;
  logic [Channel-1:0] w_push;
  logic [Channel-1:0] w_pop;
  logic [Channel-1:0] w_nonempty;

  // ---------------------------------------------------------------------------
  // Output stage state
  // ---------------------------------------------------------------------------
  logic          r_tvalid;
  logic [63:0]   r_tdata;
  logic [CW-1:0] r_tuser;
  logic          r_tlast;
  logic [CW-1:0] r_rr;
  logic [31:0]   r_beat;
  logic          r_done;

  logic          w_found;
  logic [CW-1:0] w_grant;
  logic [CW-1:0] w_rr_nx;
  logic          w_hs;
  logic          w_load;
  logic [31:0]   w_beat_nx;
  logic          w_tlast_nx;

  // A lane may capture only while the FIFO can still take the word being
  // assembled: the half flag stands for the slot reserved by a first half.
  always_comb begin
    w_slot     = '0;
    w_cap      = '0;
    w_push     = '0;
    w_nonempty = '0;
    for (int i = 0; i < Channel; i++) begin
      w_slot[i]     = (int'(r_cnt[i]) + int'(r_half[i])) < FIFO_DEPTH;
      w_cap[i]      = (r_st[i] == ST_IDLE) && r_req_s2[i] && w_slot[i];
      w_push[i]     = w_cap[i] && r_half[i];
      w_nonempty[i] = (r_cnt[i] != '0);
    end
  end

  // ---------------------------------------------------------------------------
  // Stage: synchroniser, handshake FSM and FIFO bookkeeping per lane
  // ---------------------------------------------------------------------------
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      r_req_s1 <= '0;
      r_req_s2 <= '0;
      r_ack    <= '0;
      r_half   <= '0;
      for (int i = 0; i < Channel; i++) begin
        r_st[i]  <= ST_IDLE;
        r_wp[i]  <= '0;
        r_rp[i]  <= '0;
        r_cnt[i] <= '0;
      end
    end else begin
      r_req_s1 <= request;
      r_req_s2 <= r_req_s1;
      for (int i = 0; i < Channel; i++) begin
        case (r_st[i])
          ST_IDLE: begin
            if (w_cap[i]) begin
              r_st[i]   <= ST_ACK;
              r_ack[i]  <= 1'b1;
              r_half[i] <= ~r_half[i];
            end
          end
          ST_ACK: begin
            if (!r_req_s2[i]) begin
              r_st[i]  <= ST_IDLE;
              r_ack[i] <= 1'b0;
            end
          end
          default: begin
            r_st[i]  <= ST_IDLE;
            r_ack[i] <= 1'b0;
          end
        endcase

        if (w_push[i]) r_wp[i] <= r_wp[i] + 1'b1;
        if (w_pop[i])  r_rp[i] <= r_rp[i] + 1'b1;

        // Simultaneous push and pop leaves the occupancy unchanged.
        case ({w_push[i], w_pop[i]})
          2'b10:   r_cnt[i] <= r_cnt[i] + 1'b1;
          2'b01:   r_cnt[i] <= r_cnt[i] - 1'b1;
          default: r_cnt[i] <= r_cnt[i];
        endcase
      end
    end
  end

  // din is sampled without synchronisation: the bundled-data rule keeps it
  // stable for as long as the synchronised request is seen high.
  always_ff @(posedge s_axis_aclk) begin
    for (int i = 0; i < Channel; i++) begin
      if (w_cap[i] && !r_half[i]) r_hi[i] <= din[i*32 +: 32];
      if (w_push[i]) r_mem[i][r_wp[i]] <= {r_hi[i], din[i*32 +: 32]};
    end
  end

  // ---------------------------------------------------------------------------
  // Stage: round-robin grant and output register
  // ---------------------------------------------------------------------------
  assign w_hs   = r_tvalid && m_axis.tready;
  // Reloading while the current word is being taken avoids a bubble.
  assign w_load = !r_tvalid || m_axis.tready;

  always_comb begin : p_arb
    int idx;
    int nx;
    w_found = 1'b0;
    w_grant = '0;
    idx     = 0;
    for (int k = 0; k < Channel; k++) begin
      idx = int'(r_rr) + k;
      if (idx >= Channel) idx = idx - Channel;
      if (!w_found && w_nonempty[idx]) begin
        w_found = 1'b1;
        w_grant = idx[CW-1:0];
      end
    end
    nx = int'(w_grant) + 1;
    if (nx >= Channel) nx = 0;
    w_rr_nx = nx[CW-1:0];
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < Channel; i++) begin
      w_pop[i] = w_load && w_found && (int'(w_grant) == i);
    end
  end

  // tlast is decided when a word is loaded, using the beat count that will
  // hold once this cycle's handshake (if any) has been counted.
  always_comb begin
    w_beat_nx = r_beat;
    if (w_hs) w_beat_nx = r_tlast ? 32'd0 : r_beat + 32'd1;
    w_tlast_nx = (i_rx_len != 32'd0) && ((w_beat_nx + 32'd1) == i_rx_len);
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
      r_tuser  <= '0;
      r_tlast  <= 1'b0;
      r_rr     <= '0;
      r_beat   <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_hs && r_tlast;
      r_beat <= w_beat_nx;
      if (w_load) begin
        r_tvalid <= w_found;
        if (w_found) begin
          r_tdata <= r_mem[w_grant][r_rp[w_grant]];
          r_tuser <= w_grant;
          r_tlast <= w_tlast_nx;
          r_rr    <= w_rr_nx;
        end else begin
          r_tlast <= 1'b0;
        end
      end
    end
  end

  assign acknowledge   = r_ack;
  assign m_axis.tvalid = r_tvalid;
  assign m_axis.tdata  = r_tdata;
  assign m_axis.tuser  = r_tuser;
  assign m_axis.tlast  = r_tlast;
  assign o_rx_done     = r_done;

endmodule
